// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: FSM encodings, MEM/WB control bit indices, bubble value.
// No logic; constants and types only.
// Imported by mem_access_stage and its MEM/WB register.
package mem_access_stage_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // Control half of the MEM/WB register when a bubble is inserted.
    localparam logic [1:0] MEMWB_BUBBLE = 2'b00;

endpackage

// File: rtl/mem_access_stage_mem2wb.sv
// MEM/WB pipeline register with load, bubble and synchronous reset.
// Latency: 1 cycle from load to output.
// Backpressure: none; the caller selects load or bubble every cycle.
module mem_access_stage_mem2wb
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              bubble,
    input  logic [1:0]        ctrl_d,
    input  logic [DATA_W-1:0] rdata_d,
    input  logic [DATA_W-1:0] alu_d,
    input  logic [REG_W-1:0]  dest_d,
    output logic [1:0]        ctrl_q,
    output logic [DATA_W-1:0] rdata_q,
    output logic [DATA_W-1:0] alu_q,
    output logic [REG_W-1:0]  dest_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q  <= MEMWB_BUBBLE;
            rdata_q <= '0;
            alu_q   <= '0;
            dest_q  <= '0;
        end else if (load) begin
            ctrl_q  <= ctrl_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            dest_q  <= dest_d;
        end else if (bubble) begin
            // Data fields hold; only the control and destination are killed.
            ctrl_q <= MEMWB_BUBBLE;
            dest_q <= '0;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives a ready-handshaked data memory and latches the MEM/WB register.
// Latency: non-memory ops 1 cycle; aligned accesses stall from the request until dmem_ready or timeout.
// Backpressure: stall freezes upstream while an access is pending; dmem_ready ends the wait.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        Mem_WB,
    input  logic              read_En,
    input  logic              write_En,
    input  logic [DATA_W-1:0] DataAddress,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [REG_W-1:0]  dest,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              stall,
    output logic [DATA_W-1:0] Write_Data,
    output logic [REG_W-1:0]  Write_Register,
    output logic              RegWrite,
    output logic              bus_err,
    output logic              align_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               mem_op;
    logic               misaligned;
    logic               start;
    logic               finish;
    logic               timeout_hit;
    logic               align_hit;
    logic               wb_load;
    logic               wb_bubble;
    logic [DATA_W-1:0]  wb_rdata_d;
    logic [1:0]         wb_ctrl_q;
    logic [DATA_W-1:0]  wb_rdata_q;
    logic [DATA_W-1:0]  wb_alu_q;
    logic [REG_W-1:0]   wb_dest_q;

    assign mem_op     = read_En | write_En;
    assign misaligned = mem_op && (DataAddress[1:0] != 2'b00);

    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        start       = 1'b0;
        finish      = 1'b0;
        timeout_hit = 1'b0;
        align_hit   = 1'b0;
        wb_load     = 1'b0;
        wb_bubble   = 1'b0;
        wb_rdata_d  = wb_rdata_q;
        case (state)
            ST_IDLE: begin
                if (misaligned) begin
                    align_hit = 1'b1;
                    wb_bubble = 1'b1;
                end else if (mem_op) begin
                    stall     = 1'b1;
                    start     = 1'b1;
                    wb_bubble = 1'b1;
                    state_nxt = ST_WAIT;
                end else begin
                    wb_load = 1'b1;
                end
            end
            ST_WAIT: begin
                // A response arriving on the expiry cycle still completes normally.
                if (dmem_ready) begin
                    wb_load   = 1'b1;
                    finish    = 1'b1;
                    state_nxt = ST_IDLE;
                    if (!dmem_we) begin
                        wb_rdata_d = dmem_rdata;
                    end
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    wb_load     = 1'b1;
                    finish      = 1'b1;
                    timeout_hit = 1'b1;
                    wb_rdata_d  = '0;
                    state_nxt   = ST_IDLE;
                end else begin
                    stall     = 1'b1;
                    wb_bubble = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            cnt        <= '0;
            bus_err    <= 1'b0;
            align_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            align_err <= align_hit;
            if (timeout_hit) begin
                bus_err <= 1'b1;
            end
            if (start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= write_En;
                dmem_addr  <= DataAddress;
                dmem_wdata <= WriteData;
                cnt        <= '0;
            end else if (finish) begin
                dmem_req <= 1'b0;
            end else if (state == ST_WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    mem_access_stage_mem2wb #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem2wb (
        .clk     (clk),
        .rst     (rst),
        .load    (wb_load),
        .bubble  (wb_bubble),
        .ctrl_d  (Mem_WB),
        .rdata_d (wb_rdata_d),
        .alu_d   (DataAddress),
        .dest_d  (dest),
        .ctrl_q  (wb_ctrl_q),
        .rdata_q (wb_rdata_q),
        .alu_q   (wb_alu_q),
        .dest_q  (wb_dest_q)
    );

    assign RegWrite       = wb_ctrl_q[WB_REGWRITE];
    assign Write_Register = wb_dest_q;
    assign Write_Data     = wb_ctrl_q[WB_MEMTOREG] ? wb_rdata_q : wb_alu_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, reset-in-WAIT sequence, then random
// instructions checked against a transaction-level reference model.
module tb_mem_access_stage;

    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic [1:0]  Mem_WB;
    logic        read_En;
    logic        write_En;
    logic [31:0] DataAddress;
    logic [31:0] WriteData;
    logic [4:0]  dest;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        stall;
    logic [31:0] Write_Data;
    logic [4:0]  Write_Register;
    logic        RegWrite;
    logic        bus_err;
    logic        align_err;

    mem_access_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .Mem_WB         (Mem_WB),
        .read_En        (read_En),
        .write_En       (write_En),
        .DataAddress    (DataAddress),
        .WriteData      (WriteData),
        .dest           (dest),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .dmem_ready     (dmem_ready),
        .stall          (stall),
        .Write_Data     (Write_Data),
        .Write_Register (Write_Register),
        .RegWrite       (RegWrite),
        .bus_err        (bus_err),
        .align_err      (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  dst;
        logic [1:0]  mwb;
        int          k;          // WAIT cycle in which dmem_ready rises; 0 = never
        logic [31:0] rdata;
        int          exp_stalls;
        logic        exp_rw;
        logic [4:0]  exp_dest;
        logic [31:0] exp_wd;
        logic        exp_align;
        logic        exp_bus;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: last ALU value, last load data, sticky bus error.
    logic [31:0] m_alu;
    logic [31:0] m_rdata;
    logic        m_bus;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [4:0] dst,
                                input logic [1:0] mwb, input int k, input logic [31:0] rdata,
                                input int es, input logic erw, input logic [4:0] ed,
                                input logic [31:0] ewd, input logic eal, input logic ebus);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.dst = dst; v.mwb = mwb;
        v.k = k; v.rdata = rdata; v.exp_stalls = es; v.exp_rw = erw; v.exp_dest = ed;
        v.exp_wd = ewd; v.exp_align = eal; v.exp_bus = ebus;
        return v;
    endfunction

    // Starts and ends one cycle unit past a rising edge; runs one instruction to retirement.
    task automatic run_instr(input string tag, input vec_t v);
        int   j = 0;
        int   stalls = 0;
        bit   fin = 0;
        bit   req_ok = 1;
        bit   hold_ok = 1;
        logic aligned;
        aligned     = (v.rd | v.wr) && (v.addr[1:0] == 2'b00);
        read_En     = v.rd;
        write_En    = v.wr;
        DataAddress = v.addr;
        WriteData   = v.wdata;
        dest        = v.dst;
        Mem_WB      = v.mwb;
        dmem_ready  = 1'b0;
        dmem_rdata  = $urandom;
        while (!fin) begin
            @(negedge clk);
            if (dmem_req !== (aligned && j >= 1)) req_ok = 0;
            if (aligned && j >= 1 &&
                (dmem_we !== v.wr || dmem_addr !== v.addr || dmem_wdata !== v.wdata)) hold_ok = 0;
            if (stall === 1'b1) stalls++;
            else fin = 1;
            if (j > TMO + 2) fin = 1;
            @(posedge clk); #1;
            j++;
            dmem_ready = (j == v.k);
            dmem_rdata = (j == v.k) ? v.rdata : $urandom;
        end
        dmem_ready = 1'b0;
        chk({tag, "_stall_cycles"}, stalls, v.exp_stalls);
        chk({tag, "_dmem_req"}, req_ok, 1);
        if (aligned) chk({tag, "_dmem_hold"}, hold_ok, 1);
        chk({tag, "_req_done"}, dmem_req, 0);
        chk({tag, "_RegWrite"}, RegWrite, v.exp_rw);
        chk({tag, "_Write_Register"}, Write_Register, v.exp_dest);
        chk({tag, "_Write_Data"}, Write_Data, v.exp_wd);
        chk({tag, "_align_err"}, align_err, v.exp_align);
        chk({tag, "_bus_err"}, bus_err, v.exp_bus);
    endtask

    // Builds a random instruction and its expected outcome from the stage's rules.
    task automatic make_random(output vec_t v);
        int   op;
        logic timed_out;
        op      = $urandom_range(0, 3);
        v.rd    = (op == 1 || op == 3);
        v.wr    = (op >= 2);
        v.addr  = $urandom;
        if ($urandom_range(0, 3) != 0) v.addr[1:0] = 2'b00;
        v.wdata = $urandom;
        v.dst   = 5'($urandom);
        v.mwb   = 2'($urandom);
        v.k     = $urandom_range(0, 7);
        v.rdata = $urandom;
        v.exp_align = 1'b0;
        if (!(v.rd | v.wr)) begin
            v.exp_stalls = 0;
            m_alu        = v.addr;
            v.exp_rw     = v.mwb[1];
            v.exp_dest   = v.dst;
            v.exp_wd     = v.mwb[0] ? m_rdata : m_alu;
        end else if (v.addr[1:0] != 2'b00) begin
            v.exp_stalls = 0;
            v.exp_rw     = 1'b0;
            v.exp_dest   = 5'd0;
            v.exp_wd     = m_alu;
            v.exp_align  = 1'b1;
        end else begin
            timed_out    = (v.k == 0) || (v.k > TMO + 1);
            v.exp_stalls = timed_out ? TMO + 1 : v.k;
            if (timed_out) begin
                m_rdata = 32'd0;
                m_bus   = 1'b1;
            end else if (!v.wr) begin
                m_rdata = v.rdata;
            end
            m_alu      = v.addr;
            v.exp_rw   = v.mwb[1];
            v.exp_dest = v.dst;
            v.exp_wd   = v.mwb[0] ? m_rdata : m_alu;
        end
        v.exp_bus = m_bus;
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        //           rd  wr  addr          wdata         dst    mwb    k  rdata         stl rw dest   Write_Data    al bus
        tbl[0] = mk(0, 0, 32'h0000_0040, 32'h0,        5'd8,  2'b10, 0, 32'h0,        0,  1, 5'd8,  32'h0000_0040, 0, 0);
        tbl[1] = mk(1, 0, 32'h0000_0100, 32'h0,        5'd3,  2'b11, 1, 32'hCAFE_F00D, 1, 1, 5'd3,  32'hCAFE_F00D, 0, 0);
        tbl[2] = mk(0, 1, 32'h0000_0020, 32'h1234,     5'd0,  2'b00, 3, 32'h0,        3,  0, 5'd0,  32'h0000_0020, 0, 0);
        tbl[3] = mk(1, 1, 32'h0000_0024, 32'hBEEF,     5'd9,  2'b01, 2, 32'h1111,     2,  0, 5'd9,  32'hCAFE_F00D, 0, 0);
        tbl[4] = mk(1, 0, 32'h0000_0102, 32'h0,        5'd7,  2'b11, 1, 32'h0,        0,  0, 5'd0,  32'h0000_0024, 1, 0);
        tbl[5] = mk(1, 0, 32'h0000_0200, 32'h0,        5'd12, 2'b11, 0, 32'h0,        5,  1, 5'd12, 32'h0,         0, 1);
        tbl[6] = mk(0, 0, 32'h0000_0007, 32'h0,        5'd31, 2'b10, 0, 32'h0,        0,  1, 5'd31, 32'h0000_0007, 0, 1);
        tbl[7] = mk(1, 0, 32'h0000_0300, 32'h0,        5'd4,  2'b11, 5, 32'h55AA,     5,  1, 5'd4,  32'h0000_55AA, 0, 1);

        rst = 1'b1; Mem_WB = 2'b00; read_En = 1'b0; write_En = 1'b0;
        DataAddress = 32'h0; WriteData = 32'h0; dest = 5'd0;
        dmem_rdata = 32'h0; dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_RegWrite", RegWrite, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_align_err", align_err, 0);
        chk("rst_Write_Register", Write_Register, 0);
        chk("rst_Write_Data", Write_Data, 0);
        chk("rst_stall", stall, 0);

        for (int i = 0; i < 8; i++) run_instr($sformatf("vec%0d", i), tbl[i]);

        // Reset asserted while waiting on memory; a late ready must be ignored.
        read_En = 1'b1; write_En = 1'b0; DataAddress = 32'h400; Mem_WB = 2'b11; dest = 5'd6;
        dmem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstw_pre_stall", stall, 1);
        chk("rstw_pre_req", dmem_req, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; read_En = 1'b0; Mem_WB = 2'b00; DataAddress = 32'h0; dest = 5'd0;
        @(negedge clk);
        chk("rstw_req_low", dmem_req, 0);
        chk("rstw_stall_low", stall, 0);
        chk("rstw_bus_cleared", bus_err, 0);
        @(posedge clk); #1;
        dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rstw_late_ready_req", dmem_req, 0);
        chk("rstw_late_ready_stall", stall, 0);
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        chk("rstw_late_RegWrite", RegWrite, 0);
        chk("rstw_late_Write_Data", Write_Data, 0);
        chk("rstw_late_bus_err", bus_err, 0);

        m_alu = 32'h0; m_rdata = 32'h0; m_bus = 1'b0;
        for (int i = 0; i < 150; i++) begin
            make_random(rv);
            run_instr($sformatf("rnd%0d", i), rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
